// File: rtl/pc_fetch_unit.sv
// Program counter / next-address stage feeding the instruction memory.
// Guarantees only word-aligned, in-range fetch addresses leave this block.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        BranchTaken,
  input  logic [31:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  output logic [31:0] InstrAddr,
  output logic [31:0] PcPlus4,
  output logic        Running,
  output logic        AddrFault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cand;
  logic        cand_bad;

  assign InstrAddr = pc_q;
  assign PcPlus4   = pc_q + 32'd4;

  // Candidate next PC by source priority; Halt/Stall are handled in the FSM.
  always_comb begin
    cand = PcPlus4;
    if (JumpReg)
      cand = RegTarget;
    else if (Jump)
      cand = {PcPlus4[31:28], JumpTarget, 2'b00};
    else if (BranchTaken)
      cand = PcPlus4 + (BranchOffset << 2);
    cand_bad = (cand[1:0] != 2'b00) || (cand >= MEM_BYTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A faulting candidate never reaches the PC: it keeps the last legal value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (Halt)
          state_d = HALTED;
        else if (!Stall) begin
          if (cand_bad)
            state_d = FAULT;
          else
            pc_d = cand;
        end
      end
      default: begin
        state_d = state_q;
        pc_d    = pc_q;
      end
    endcase
  end

  always_comb begin
    Running   = (state_q == RUN);
    AddrFault = (state_q == FAULT);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: vector table, directed corner sequences and
// randomized traffic checked against a behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_WORDS = 64;

  // Handshake-free block: every input is sampled at each rising edge and the
  // outputs reflect it after that edge; the bench drives and samples on the
  // falling edge.
  logic        clk, rst_n;
  logic        Stall, Halt, BranchTaken, Jump, JumpReg;
  logic [31:0] BranchOffset, RegTarget;
  logic [25:0] JumpTarget;
  logic [31:0] InstrAddr, PcPlus4;
  logic        Running, AddrFault;
  logic [1:0]  dbg_state;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Halt(Halt),
    .BranchTaken(BranchTaken), .BranchOffset(BranchOffset), .Jump(Jump),
    .JumpTarget(JumpTarget), .JumpReg(JumpReg), .RegTarget(RegTarget),
    .InstrAddr(InstrAddr), .PcPlus4(PcPlus4), .Running(Running),
    .AddrFault(AddrFault), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected {pc, running, fault}
  logic [33:0] exp_q[$];

  // model: mode 0 boot, 1 run, 2 halted, 3 fault
  int          m_mode;
  logic [31:0] m_pc;

  typedef struct {
    logic        stall, halt, br;
    logic [31:0] off;
    logic        j;
    logic [25:0] jt;
    logic        jr;
    logic [31:0] rt;
    logic [31:0] e_pc;
    logic        e_run, e_flt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ht, input logic br, input logic [31:0] off,
                       input logic j, input logic [25:0] jt, input logic jr, input logic [31:0] rt);
    Stall = st; Halt = ht; BranchTaken = br; BranchOffset = off;
    Jump = j; JumpTarget = jt; JumpReg = jr; RegTarget = rt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] nxt, base;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      base = m_pc + 32'd4;
      if (Halt) m_mode = 2;
      else if (!Stall) begin
        if (JumpReg)          nxt = RegTarget;
        else if (Jump)        nxt = (base & 32'hF000_0000) + {6'd0, JumpTarget} * 32'd4;
        else if (BranchTaken) nxt = base + BranchOffset * 32'd4;
        else                  nxt = base;
        if ((nxt % 4 != 0) || (nxt >= MEM_WORDS * 4)) m_mode = 3;
        else m_pc = nxt;
      end
    end
  endtask

  task automatic compare_outputs(input string name);
    logic [33:0] e;
    e = exp_q.pop_front();
    check({name, ".addr"}, InstrAddr, e[33:2]);
    check({name, ".pp4"}, PcPlus4, e[33:2] + 32'd4);
    check({name, ".flags"}, {30'd0, Running, AddrFault}, {30'd0, e[1:0]});
  endtask

  // One clock; expectation comes from the model.
  task automatic step(input string name);
    model_step();
    exp_q.push_back({m_pc, m_mode == 1, m_mode == 3});
    @(negedge clk);
    compare_outputs(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    m_pc = RESET_PC; m_mode = 0;
    check("reset.addr", InstrAddr, RESET_PC);
    check("reset.flags", {30'd0, Running, AddrFault}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Reset pulsed between edges: outputs must clear before any clock edge.
  task automatic async_reset_check(input string name);
    #2 rst_n = 1'b0;
    #1;
    check({name, ".addr"}, InstrAddr, RESET_PC);
    check({name, ".fault"}, {31'd0, AddrFault}, 32'd0);
    check({name, ".run"}, {31'd0, Running}, 32'd0);
    @(negedge clk);
    m_pc = RESET_PC; m_mode = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    idle();
    //          st ht br off           j  jt      jr rt            pc     run flt
    vecs[0]  = '{0, 0, 0, 32'h0,       0, 26'h0,  0, 32'h0,   32'h00, 1, 0};
    vecs[1]  = '{0, 0, 0, 32'h0,       0, 26'h0,  0, 32'h0,   32'h04, 1, 0};
    vecs[2]  = '{0, 0, 0, 32'h0,       0, 26'h0,  0, 32'h0,   32'h08, 1, 0};
    vecs[3]  = '{1, 0, 0, 32'h0,       0, 26'h0,  0, 32'h0,   32'h08, 1, 0};
    vecs[4]  = '{1, 0, 1, 32'h3,       0, 26'h0,  0, 32'h0,   32'h08, 1, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,       0, 26'h0,  0, 32'h0,   32'h0C, 1, 0};
    vecs[6]  = '{0, 0, 0, 32'h0,       0, 26'h0,  0, 32'h0,   32'h10, 1, 0};
    vecs[7]  = '{0, 0, 1, 32'hFFFF_FFFE, 0, 26'h0, 0, 32'h0,  32'h0C, 1, 0};
    vecs[8]  = '{0, 0, 0, 32'h0,       1, 26'h8,  0, 32'h0,   32'h20, 1, 0};
    vecs[9]  = '{0, 0, 1, 32'h5,       1, 26'h10, 0, 32'h0,   32'h40, 1, 0};
    vecs[10] = '{0, 0, 1, 32'h1,       1, 26'h3,  1, 32'h80,  32'h80, 1, 0};
    vecs[11] = '{0, 0, 0, 32'h0,       0, 26'h0,  1, 32'hFC,  32'hFC, 1, 0};
    vecs[12] = '{0, 0, 0, 32'h0,       0, 26'h0,  0, 32'h0,   32'hFC, 0, 1};
    vecs[13] = '{0, 0, 0, 32'h0,       1, 26'h1,  0, 32'h0,   32'hFC, 0, 1};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      drive(v.stall, v.halt, v.br, v.off, v.j, v.jt, v.jr, v.rt);
      model_step();
      exp_q.push_back({v.e_pc, v.e_run, v.e_flt});
      @(negedge clk);
      compare_outputs($sformatf("vec%0d", i));
    end

    // fault state cleared by an asynchronous reset
    async_reset_check("areset_fault");

    // Halt outranks Jump, and is sticky
    idle(); step("h.boot");
    step("h.seq1");
    step("h.seq2");
    drive(0, 1, 0, 0, 1, 26'h20, 0, 0); step("h.halt_jump");
    idle(); step("h.frozen1");
    drive(0, 0, 0, 0, 0, 0, 1, 32'h40); step("h.frozen2");
    async_reset_check("areset_halt");

    // misaligned jump-register target
    idle(); step("m.boot");
    step("m.seq");
    drive(0, 0, 0, 0, 0, 0, 1, 32'h6); step("m.jr6");
    idle(); step("m.stuck");
    do_reset();

    // Stall outranks Jump; branch offset arithmetic wraps mod 2^32
    idle(); step("w.boot");
    drive(1, 0, 0, 0, 1, 26'h20, 0, 0); step("w.stall_jump");
    idle(); step("w.seq");
    drive(0, 0, 1, 32'hC000_0001, 0, 0, 0, 0); step("w.wrap");
    drive(0, 0, 1, 32'h8000_0000, 0, 0, 0, 0); step("w.zero_shift");
    drive(0, 0, 1, 32'h0000_0100, 0, 0, 0, 0); step("w.range");
    do_reset();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ((m_mode == 2 || m_mode == 3) && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) do_reset();
        else async_reset_check("r.areset");
      end
      drive($urandom_range(0, 5) == 0,
            $urandom_range(0, 50) == 0,
            $urandom_range(0, 3) == 0,
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : -32'($urandom_range(0, 8)),
            $urandom_range(0, 5) == 0,
            26'($urandom_range(0, 70)),
            $urandom_range(0, 6) == 0,
            ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 68)) * 32'd4);
      step($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
